// File: rtl/cp0_ex_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// cp0_ex_sequencer_pkg : CP0 register numbers, ExcCodes, sequencer states
// Revision 1.0 -- CP0_BADVADDR_EN adds the EX_BADV state
// ============================================================================
package cp0_ex_sequencer_pkg;

  typedef enum logic [4:0] {
    CP0_BADVADDR = 5'd8,
    CP0_STATUS   = 5'd12,
    CP0_CAUSE    = 5'd13,
    CP0_EPC      = 5'd14,
    CP0_UNUSED   = 5'd31
  } cp0_reg_e;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int STATUS_EXL = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EX_EPC    = 3'd1,
    ST_EX_CAUSE  = 3'd2,
    ST_EX_STATUS = 3'd3,
`ifdef CP0_BADVADDR_EN
    ST_EX_BADV   = 3'd4,
`endif
    ST_ER_STATUS = 3'd5,
    ST_ER_EPC    = 3'd6,
    ST_REDIRECT  = 3'd7
  } seq_state_e;

  function automatic logic [31:0] status_with_exl(input logic [31:0] status,
                                                  input logic        exl);
    status_with_exl             = status;
    status_with_exl[STATUS_EXL] = exl;
  endfunction

  // BD and ExcCode replace their fields; IP[15:8] and the upper bits survive.
  function automatic logic [31:0] cause_update(input logic [31:0] cause,
                                               input logic        bd,
                                               input logic [4:0]  code);
    cause_update = {bd, cause[30:16], cause[15:8], 1'b0, code, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_req_prio.sv
`default_nettype none
// ============================================================================
// cp0_req_prio : 4-way fixed-priority one-hot grant, bit 0 highest
// Revision 1.0
// ============================================================================
module cp0_req_prio (
  input  logic [3:0] req_i,
  output logic [3:0] grant_o
);

  // Isolate the lowest set request bit.
  assign grant_o = req_i & (~req_i + 4'd1);

endmodule
`default_nettype wire

// File: rtl/cp0_ex_sequencer.sv
`default_nettype none
// ============================================================================
// cp0_ex_sequencer : arbitrates exception entry, ERET, MTC0 and MFC0 onto CP0
// Revision 1.0 -- define CP0_BADVADDR_EN to write BadVAddr on AdEL/AdES
// ============================================================================
module cp0_ex_sequencer
  import cp0_ex_sequencer_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = 32'hBFC00380,
  parameter logic [31:0] BD_ADJUST = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_code_i,
  input  logic        ex_bd_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_badvaddr_i,
  output logic        ex_ack_o,
  input  logic        eret_valid_i,
  output logic        eret_ack_o,
  input  logic        mtc0_req_i,
  input  logic [4:0]  mtc0_addr_i,
  input  logic [31:0] mtc0_wdata_i,
  output logic        mtc0_ack_o,
  input  logic        mfc0_req_i,
  input  logic [4:0]  mfc0_addr_i,
  output logic [31:0] mfc0_rdata_o,
  output logic        mfc0_ack_o,
  output logic [4:0]  cp0_raddr_o,
  input  logic [31:0] cp0_rdata_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        busy_o,
  output logic        pipe_flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  seq_state_e  state_q, state_d;
  logic        pipe_flush_q, pipe_flush_d;
  logic        is_ex_q;
  logic [4:0]  code_q;
  logic        bd_q;
  logic [31:0] pc_q;
  logic [31:0] target_q;
  logic [3:0]  req, grant;
  logic        take_ex, take_eret;

`ifdef CP0_BADVADDR_EN
  logic [31:0] badv_q;
`else
  logic unused_badvaddr;
  assign unused_badvaddr = ^ex_badvaddr_i;
`endif

  assign req = {mfc0_req_i, mtc0_req_i, eret_valid_i, ex_valid_i};

  cp0_req_prio u_prio (
    .req_i   (req),
    .grant_o (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pipe_flush_q <= 1'b0;
      is_ex_q      <= 1'b0;
      code_q       <= '0;
      bd_q         <= 1'b0;
      pc_q         <= '0;
      target_q     <= '0;
`ifdef CP0_BADVADDR_EN
      badv_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pipe_flush_q <= pipe_flush_d;
      if (take_ex) begin
        is_ex_q <= 1'b1;
        code_q  <= ex_code_i;
        bd_q    <= ex_bd_i;
        pc_q    <= ex_pc_i;
`ifdef CP0_BADVADDR_EN
        badv_q  <= ex_badvaddr_i;
`endif
      end
      if (take_eret) is_ex_q <= 1'b0;
      if (state_q == ST_ER_EPC) target_q <= cp0_rdata_i;
    end
  end

  // Reset gates every port action so an abandoned sequence issues no CP0 write.
  always_comb begin
    state_d          = state_q;
    take_ex          = 1'b0;
    take_eret        = 1'b0;
    ex_ack_o         = 1'b0;
    eret_ack_o       = 1'b0;
    mtc0_ack_o       = 1'b0;
    mfc0_ack_o       = 1'b0;
    mfc0_rdata_o     = '0;
    cp0_raddr_o      = CP0_UNUSED;
    cp0_we_o         = 1'b0;
    cp0_waddr_o      = CP0_UNUSED;
    cp0_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (grant[0]) begin
            ex_ack_o = 1'b1;
            take_ex  = 1'b1;
            state_d  = ST_EX_EPC;
          end else if (grant[1]) begin
            eret_ack_o = 1'b1;
            take_eret  = 1'b1;
            state_d    = ST_ER_STATUS;
          end else if (grant[2]) begin
            mtc0_ack_o  = 1'b1;
            cp0_we_o    = 1'b1;
            cp0_waddr_o = mtc0_addr_i;
            cp0_wdata_o = mtc0_wdata_i;
          end else if (grant[3]) begin
            mfc0_ack_o   = 1'b1;
            cp0_raddr_o  = mfc0_addr_i;
            mfc0_rdata_o = cp0_rdata_i;
          end
        end
        ST_EX_EPC: begin
          cp0_raddr_o = CP0_STATUS;
          // A nested exception keeps the original EPC.
          if (!cp0_rdata_i[STATUS_EXL]) begin
            cp0_we_o    = 1'b1;
            cp0_waddr_o = CP0_EPC;
            cp0_wdata_o = pc_q - (bd_q ? BD_ADJUST : 32'd0);
          end
          state_d = ST_EX_CAUSE;
        end
        ST_EX_CAUSE: begin
          cp0_raddr_o = CP0_CAUSE;
          cp0_we_o    = 1'b1;
          cp0_waddr_o = CP0_CAUSE;
          cp0_wdata_o = cause_update(cp0_rdata_i, bd_q, code_q);
          state_d     = ST_EX_STATUS;
        end
        ST_EX_STATUS: begin
          cp0_raddr_o = CP0_STATUS;
          cp0_we_o    = 1'b1;
          cp0_waddr_o = CP0_STATUS;
          cp0_wdata_o = status_with_exl(cp0_rdata_i, 1'b1);
          state_d     = ST_REDIRECT;
`ifdef CP0_BADVADDR_EN
          if (code_q == EXC_ADEL || code_q == EXC_ADES) state_d = ST_EX_BADV;
`endif
        end
`ifdef CP0_BADVADDR_EN
        ST_EX_BADV: begin
          cp0_we_o    = 1'b1;
          cp0_waddr_o = CP0_BADVADDR;
          cp0_wdata_o = badv_q;
          state_d     = ST_REDIRECT;
        end
`endif
        ST_ER_STATUS: begin
          cp0_raddr_o = CP0_STATUS;
          cp0_we_o    = 1'b1;
          cp0_waddr_o = CP0_STATUS;
          cp0_wdata_o = status_with_exl(cp0_rdata_i, 1'b0);
          state_d     = ST_ER_EPC;
        end
        ST_ER_EPC: begin
          cp0_raddr_o = CP0_EPC;
          state_d     = ST_REDIRECT;
        end
        ST_REDIRECT: begin
          redirect_valid_o = 1'b1;
          redirect_pc_o    = is_ex_q ? EX_ENTRY : target_q;
          state_d          = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Flush covers the exception path only, from the cycle after accept through REDIRECT.
  always_comb begin
    pipe_flush_d = 1'b0;
    case (state_d)
      ST_EX_EPC, ST_EX_CAUSE, ST_EX_STATUS: pipe_flush_d = 1'b1;
`ifdef CP0_BADVADDR_EN
      ST_EX_BADV:                           pipe_flush_d = 1'b1;
`endif
      ST_REDIRECT:                          pipe_flush_d = is_ex_q;
      default:                              pipe_flush_d = 1'b0;
    endcase
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign pipe_flush_o = pipe_flush_q;

endmodule
`default_nettype wire
